// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and helpers for the lab processor datapath
package proc_pkg;

    localparam int DATA_WIDTH_DEFAULT = 9;
    localparam int IR_WIDTH           = 9;
    localparam int NUM_REGS           = 8;
    localparam int SEL_WIDTH          = 10;

    // Bus select bit positions in MUXLINE
    localparam int SEL_DIN = 9;
    localparam int SEL_G   = 8;

    // Write enable bit positions in REGSELECTORS
    localparam int EN_G = 9;
    localparam int EN_A = 8;

    // Instruction fields IIIXXXYYY
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int RX_MSB  = 5;
    localparam int RX_LSB  = 3;
    localparam int RY_MSB  = 2;
    localparam int RY_LSB  = 0;

    // True when more than one select bit is set (clearing the lowest set bit leaves something)
    function automatic logic multi_hot(input logic [SEL_WIDTH-1:0] v);
        logic [SEL_WIDTH-1:0] v_m1;
        v_m1 = v - SEL_WIDTH'(1);
        return |(v & v_m1);
    endfunction

endpackage

// File: rtl/proc_datapath_if.sv
// rtl/proc_datapath_if.sv - control unit <-> datapath signal bundle
interface proc_datapath_if import proc_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic                  RUN;
    logic [DATA_WIDTH-1:0] DIN;
    logic [SEL_WIDTH-1:0]  MUXLINE;
    logic [SEL_WIDTH-1:0]  REGSELECTORS;
    logic                  ADDSUB;
    logic                  IREN;
    logic                  COUNTERCLR;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] BUSWIRES;
    logic [IR_WIDTH-1:0]   IRLINE;
    logic [1:0]            COUNTERLINE;
    logic [DATA_WIDTH-1:0] GOUT;
    logic                  MUXERR;

    modport master (
        output RUN, DIN, MUXLINE, REGSELECTORS, ADDSUB, IREN, COUNTERCLR, DONE,
        input  BUSWIRES, IRLINE, COUNTERLINE, GOUT, MUXERR
    );

    modport slave (
        input  RUN, DIN, MUXLINE, REGSELECTORS, ADDSUB, IREN, COUNTERCLR, DONE,
        output BUSWIRES, IRLINE, COUNTERLINE, GOUT, MUXERR
    );

endinterface

// File: rtl/datapath_reg.sv
// rtl/datapath_reg.sv - load-enabled register with synchronous active-high reset
module datapath_reg #(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q;

    // Reset dominates; otherwise capture d_i when enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= '0;
        end else if (en_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/proc_datapath.sv
// rtl/proc_datapath.sv - register file, bus mux, add/sub and step counter
module proc_datapath import proc_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    proc_datapath_if.slave dp
);

    logic [DATA_WIDTH-1:0] r_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] g_q;
    logic [DATA_WIDTH-1:0] g_d;
    logic [IR_WIDTH-1:0]   ir_q;
    logic [DATA_WIDTH-1:0] bus_w;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    // General registers R0..R7 all load from the bus
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        datapath_reg #(.WIDTH(DATA_WIDTH)) u_r (
            .clk_i (CLK),
            .rst_i (RESET),
            .en_i  (dp.REGSELECTORS[gi]),
            .d_i   (bus_w),
            .q_o   (r_q[gi])
        );
    end

    datapath_reg #(.WIDTH(DATA_WIDTH)) u_a (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (dp.REGSELECTORS[EN_A]),
        .d_i   (bus_w),
        .q_o   (a_q)
    );

    datapath_reg #(.WIDTH(DATA_WIDTH)) u_g (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (dp.REGSELECTORS[EN_G]),
        .d_i   (g_d),
        .q_o   (g_q)
    );

    // IR loads straight from DIN so an instruction fetch never needs the bus
    datapath_reg #(.WIDTH(IR_WIDTH)) u_ir (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (dp.IREN),
        .d_i   (dp.DIN[IR_WIDTH-1:0]),
        .q_o   (ir_q)
    );

    // Bus mux: DIN over G over lowest-numbered Ri; descending loop lets the lowest index win
    always_comb begin
        bus_w = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (dp.MUXLINE[i]) begin
                bus_w = r_q[i];
            end
        end
        if (dp.MUXLINE[SEL_G]) begin
            bus_w = g_q;
        end
        if (dp.MUXLINE[SEL_DIN]) begin
            bus_w = dp.DIN;
        end
    end

    // Adder/subtractor against the pre-edge A; carry and borrow fall off the top
    always_comb begin
        g_d = a_q - bus_w;
        if (dp.ADDSUB) begin
            g_d = a_q + bus_w;
        end
    end

    // Step counter next state: clear beats advance, otherwise hold
    always_comb begin
        count_d = count_q;
        if (dp.COUNTERCLR || dp.DONE) begin
            count_d = 2'd0;
        end else if (dp.RUN) begin
            count_d = count_q + 2'd1;
        end
    end

    // Step counter register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dp.BUSWIRES    = bus_w;
    assign dp.IRLINE      = ir_q;
    assign dp.COUNTERLINE = count_q;
    assign dp.GOUT        = g_q;
    assign dp.MUXERR      = multi_hot(dp.MUXLINE);

endmodule

// File: doc/proc_datapath.md
# proc_datapath

Datapath and step-sequencing stage for the 9-bit lab processor, directly downstream of the control unit. It holds R0–R7, the accumulator A, the result register G and the instruction register IR, and drives the shared bus from the control unit's one-hot mux selects. It performs add/subtract into G and owns the 2-bit time-step counter that the control unit decodes. It produces IRLINE and COUNTERLINE, which close the loop back to the control unit.

## Interface
- DATA_WIDTH, 9, width of bus, all registers and DIN; IR always 9 bits (IIIXXXYYY)
- CLK  input  1  rising-edge clock for all state
- RESET  input  1  synchronous, active-high
- RUN  input  1  step counter advances only while high
- DIN  input  DATA_WIDTH  external data input, bus source and IR load source
- MUXLINE  input  10  bus select: [7:0] R0..R7, [8] G, [9] DIN
- REGSELECTORS  input  10  write enables: [7:0] R0..R7, [8] A, [9] G
- ADDSUB  input  1  1 = G ← A + BUS, 0 = G ← A − BUS
- IREN  input  1  IR ← DIN at next edge
- COUNTERCLR  input  1  clear step counter
- DONE  input  1  instruction complete; clear step counter
- BUSWIRES  output  DATA_WIDTH  current bus value (combinational)
- IRLINE  output  9  IR contents
- COUNTERLINE  output  2  step counter value
- GOUT  output  DATA_WIDTH  G contents
- MUXERR  output  1  combinational; high when more than one MUXLINE bit is set

## Operation
- Bus, combinational, fixed priority: DIN if MUXLINE[9]; else G if MUXLINE[8]; else the lowest-index Ri with MUXLINE[i]=1; else all zeros.
- MUXERR = popcount(MUXLINE) > 1. The bus value still follows the priority rule.
- Register writes happen on a rising edge: Ri ← BUS when REGSELECTORS[i]=1, and A ← BUS when REGSELECTORS[8]=1.
- G ← (A ± BUS) mod 2^DATA_WIDTH when REGSELECTORS[9]=1, using the pre-edge A. Carry and borrow are discarded.
- IR ← DIN[8:0] when IREN=1. IREN is independent of the bus.
- Step counter, evaluated per edge in priority order:
  - RESET → 0
  - COUNTERCLR or DONE → 0
  - RUN → +1, wrapping 3→0
  - otherwise hold
- Self-transfer (select Ri and enable Ri) leaves Ri unchanged.
- Any number of write enables may be active at once; every enabled target receives the same BUS value.

## Timing
- Reset value of all registers, IR, G and the counter is 0. Outputs after reset: BUSWIRES = 0 with MUXLINE=0, IRLINE=0, COUNTERLINE=0, GOUT=0. MUXERR is purely combinational.
- Write latency is 1 cycle: a value is visible on the register output and on the bus at the edge after its enable.
- The step advances exactly once per edge with RUN=1, so the 0→1→2→3 sequence takes 3 edges.
- DONE is sampled at the same edge as the last-step writes. The counter reads 0 in the following cycle and the writes still complete.
- RESET mid-instruction aborts the instruction. Writes enabled in that cycle are discarded and all state returns to 0.
- A and G enabled in the same cycle: A takes BUS, and G uses the old A.

## Structure
- Shared package proc_pkg holds:
  - DATA_WIDTH default
  - select bit indices: SEL_DIN=9, SEL_G=8, EN_G=9, EN_A=8
  - opcode field positions [8:6], [5:3], [2:0]
- Sub-module datapath_reg: DATA_WIDTH-parameterised register with synchronous reset and load enable. It is instantiated for R0–R7, A, G and IR (IR with width 9).
- The bus mux, adder/subtractor and step counter are inline in proc_datapath.

## Test plan
- Reset: set R3=0x1AB, assert RESET for 1 cycle → R3=0, IRLINE=0, COUNTERLINE=0, GOUT=0.
- Load and move:
  - DIN=0x055, MUXLINE[9], REGSELECTORS[0] → R0=0x055 next cycle.
  - Then MUXLINE[0], REGSELECTORS[5] → R5=0x055.
- Add and subtract:
  - Add with wrap: A=0x1F0, bus R1=0x020, ADDSUB=1 → GOUT=0x010.
  - Subtract with borrow: A=0x003, bus R1=0x005, ADDSUB=0 → GOUT=0x1FE.
  - Then MUXLINE[8], REGSELECTORS[2] → R2=0x1FE.
- Counter:
  - RUN=1 for 5 edges → COUNTERLINE 1,2,3,0,1.
  - DONE with RUN=1 → 0.
  - RUN=0 → hold.
  - COUNTERCLR and RUN together → 0.
- Bus priority: MUXLINE=10'b11_0000_0100 with DIN=0x0AA, G=0x111, R2=0x022 → BUSWIRES=0x0AA, MUXERR=1. Select R2 alone → BUSWIRES=0x022, MUXERR=0.
- IR and mid-op reset:
  - IREN with DIN=0x10A → IRLINE=0x10A.
  - Assert RESET while COUNTERLINE=2 and REGSELECTORS[9]=1 → G stays 0 and the counter is 0.
